// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions between dispatch and retire.
// Allocates in program order, captures writeback results, feeds operands and retires from the head.
module rob #(
    parameter int ROB_DEPTH      = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int PC_WIDTH       = 32,
    localparam int TAG_W         = $clog2(ROB_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_req,
    input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    input  logic                      alloc_dst_wen,
    input  logic [PC_WIDTH-1:0]       alloc_pc,
    output logic                      alloc_ready,
    output logic                      allocate_en,
    output logic [TAG_W-1:0]          rob_alloc_tag_2rat,
    output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
    output logic                      rob_alloc_dst_wen_2rat,
    input  logic                      wb_en,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_br_taken,
    input  logic                      wb_exp_en,
    input  logic [TAG_W-1:0]          rs1_Paddr,
    input  logic [TAG_W-1:0]          rs2_Paddr,
    output logic                      rs1_rob_ready,
    output logic [DATA_WIDTH-1:0]     rs1_rob_data,
    output logic                      rs2_rob_ready,
    output logic [DATA_WIDTH-1:0]     rs2_rob_data,
    output logic                      commit_en,
    output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
    output logic                      rob_commit_dst_wen,
    output logic [DATA_WIDTH-1:0]     rob_commit_data,
    output logic [PC_WIDTH-1:0]       rob_commit_pc,
    output logic                      rob_commit_br_taken,
    output logic                      rob_commit_exp_en
);

    logic [TAG_W:0]                head, tail;
    logic [TAG_W-1:0]              head_idx, tail_idx;
    logic [ROB_DEPTH-1:0]          valid, done, br_q, exp_q, dst_wen_q;
    logic [GPR_ADDR_WIDTH-1:0]     dst_addr_q [ROB_DEPTH];
    logic [PC_WIDTH-1:0]           pc_q       [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]         data_q     [ROB_DEPTH];
    logic                          full, flush, rs1_hit, rs2_hit;

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

    assign alloc_ready             = !full;
    assign allocate_en             = alloc_req && !full && !flush;
    assign rob_alloc_tag_2rat      = tail_idx;
    assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
    assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

    // Head retires only once its result was captured on an earlier edge.
    assign commit_en                = valid[head_idx] && done[head_idx];
    assign flush                    = commit_en && (br_q[head_idx] || exp_q[head_idx]);
    assign rob_commit_dst_wen       = commit_en && dst_wen_q[head_idx] && !exp_q[head_idx];
    assign rob_commit_dst_addr_2rat = rob_commit_dst_wen ? dst_addr_q[head_idx] : '0;
    assign rob_commit_data          = commit_en ? data_q[head_idx] : '0;
    assign rob_commit_pc            = commit_en ? pc_q[head_idx] : '0;
    assign rob_commit_br_taken      = commit_en && br_q[head_idx];
    assign rob_commit_exp_en        = commit_en && exp_q[head_idx];

    assign rs1_hit       = wb_en && (wb_tag == rs1_Paddr);
    assign rs2_hit       = wb_en && (wb_tag == rs2_Paddr);
    assign rs1_rob_ready = valid[rs1_Paddr] && (done[rs1_Paddr] || rs1_hit);
    assign rs2_rob_ready = valid[rs2_Paddr] && (done[rs2_Paddr] || rs2_hit);
    assign rs1_rob_data  = !valid[rs1_Paddr] ? '0 : (rs1_hit ? wb_data : data_q[rs1_Paddr]);
    assign rs2_rob_data  = !valid[rs2_Paddr] ? '0 : (rs2_hit ? wb_data : data_q[rs2_Paddr]);

    // A flushing retire wipes the whole queue and drops any same-cycle writeback or allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            valid     <= '0;
            done      <= '0;
            br_q      <= '0;
            exp_q     <= '0;
            dst_wen_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dst_addr_q[i] <= '0;
                pc_q[i]       <= '0;
                data_q[i]     <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (wb_en && valid[wb_tag]) begin
                done[wb_tag]   <= 1'b1;
                data_q[wb_tag] <= wb_data;
                br_q[wb_tag]   <= wb_br_taken;
                exp_q[wb_tag]  <= wb_exp_en;
            end
            if (commit_en) begin
                valid[head_idx] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (allocate_en) begin
                valid[tail_idx]      <= 1'b1;
                done[tail_idx]       <= 1'b0;
                br_q[tail_idx]       <= 1'b0;
                exp_q[tail_idx]      <= 1'b0;
                dst_wen_q[tail_idx]  <= alloc_dst_wen;
                dst_addr_q[tail_idx] <= alloc_dst_addr;
                pc_q[tail_idx]       <= alloc_pc;
                data_q[tail_idx]     <= '0;
                tail                 <= tail + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed vector table plus a queue-based scoreboard model
// that predicts allocation tags, commits, operand reads and flushes every cycle.
module tb_rob;

    logic        clk, rst_n;
    logic        alloc_req, alloc_dst_wen, alloc_ready, allocate_en;
    logic [4:0]  alloc_dst_addr, rob_alloc_dst_addr_2rat, rob_commit_dst_addr_2rat;
    logic [31:0] alloc_pc, wb_data, rs1_rob_data, rs2_rob_data, rob_commit_data, rob_commit_pc;
    logic [2:0]  rob_alloc_tag_2rat, wb_tag, rs1_Paddr, rs2_Paddr;
    logic        rob_alloc_dst_wen_2rat, wb_en, wb_br_taken, wb_exp_en;
    logic        rs1_rob_ready, rs2_rob_ready, commit_en, rob_commit_dst_wen;
    logic        rob_commit_br_taken, rob_commit_exp_en;

    rob dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_dst_addr(alloc_dst_addr), .alloc_dst_wen(alloc_dst_wen),
        .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .allocate_en(allocate_en),
        .rob_alloc_tag_2rat(rob_alloc_tag_2rat), .rob_alloc_dst_addr_2rat(rob_alloc_dst_addr_2rat),
        .rob_alloc_dst_wen_2rat(rob_alloc_dst_wen_2rat),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_br_taken(wb_br_taken),
        .wb_exp_en(wb_exp_en), .rs1_Paddr(rs1_Paddr), .rs2_Paddr(rs2_Paddr),
        .rs1_rob_ready(rs1_rob_ready), .rs1_rob_data(rs1_rob_data),
        .rs2_rob_ready(rs2_rob_ready), .rs2_rob_data(rs2_rob_data),
        .commit_en(commit_en), .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
        .rob_commit_dst_wen(rob_commit_dst_wen), .rob_commit_data(rob_commit_data),
        .rob_commit_pc(rob_commit_pc), .rob_commit_br_taken(rob_commit_br_taken),
        .rob_commit_exp_en(rob_commit_exp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  dst;
        logic        wen;
        logic [31:0] pc;
        logic [31:0] data;
        logic        done;
        logic        br;
        logic        ex;
    } ent_t;

    typedef struct {
        logic        areq;
        logic [4:0]  adst;
        logic [31:0] apc;
        logic        wen;
        logic [2:0]  wtag;
        logic [31:0] wdata;
        logic        e_alloc;
        logic [2:0]  e_tag;
        logic        e_commit;
        logic [31:0] e_pc;
    } vec_t;

    ent_t       sb[$];
    vec_t       vecs[11];
    logic [2:0] model_tail;
    int         checks = 0;
    int         errors = 0;
    int         dut_commits;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic applyStimulus(input logic a_req, input logic [4:0] a_dst, input logic a_wen,
                                 input logic [31:0] a_pc, input logic w_en, input logic [2:0] w_tag,
                                 input logic [31:0] w_data, input logic w_br, input logic w_exp,
                                 input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        alloc_req = a_req; alloc_dst_addr = a_dst; alloc_dst_wen = a_wen; alloc_pc = a_pc;
        wb_en = w_en; wb_tag = w_tag; wb_data = w_data; wb_br_taken = w_br; wb_exp_en = w_exp;
        rs1_Paddr = r1; rs2_Paddr = r2;
        #1;
    endtask

    task automatic checkOperand(input string name, input logic [2:0] r, input logic rdy,
                                input logic [31:0] dat);
        logic        e_rdy;
        logic [31:0] e_dat;
        logic        hit;
        e_rdy = 1'b0;
        e_dat = '0;
        hit   = wb_en && (wb_tag == r);
        foreach (sb[i]) begin
            if (sb[i].tag == r) begin
                e_rdy = sb[i].done || hit;
                e_dat = hit ? wb_data : sb[i].data;
            end
        end
        checkOutput({name, "_ready"}, rdy, e_rdy);
        checkOutput({name, "_data"}, dat, e_dat);
    endtask

    // Compare all outputs against the scoreboard, then advance it as the rising edge will.
    task automatic modelStep();
        logic full, cm, fl, al, cwen;
        ent_t e;
        full = (sb.size() == 8);
        cm   = (sb.size() > 0) && sb[0].done;
        fl   = cm && (sb[0].br || sb[0].ex);
        al   = alloc_req && !full && !fl;
        checkOutput("alloc_ready", alloc_ready, !full);
        checkOutput("allocate_en", allocate_en, al);
        if (al) checkOutput("alloc_tag", rob_alloc_tag_2rat, model_tail);
        checkOutput("alloc_dst_pass", rob_alloc_dst_addr_2rat, alloc_dst_addr);
        checkOutput("commit_en", commit_en, cm);
        if (commit_en) dut_commits++;
        if (cm) begin
            cwen = sb[0].wen && !sb[0].ex;
            checkOutput("commit_pc", rob_commit_pc, sb[0].pc);
            checkOutput("commit_data", rob_commit_data, sb[0].data);
            checkOutput("commit_dst_wen", rob_commit_dst_wen, cwen);
            checkOutput("commit_dst_addr", rob_commit_dst_addr_2rat, cwen ? sb[0].dst : 5'd0);
            checkOutput("commit_br", rob_commit_br_taken, sb[0].br);
            checkOutput("commit_exp", rob_commit_exp_en, sb[0].ex);
        end else begin
            checkOutput("idle_commit_pc", rob_commit_pc, 0);
            checkOutput("idle_commit_data", rob_commit_data, 0);
            checkOutput("idle_commit_flags",
                        {rob_commit_dst_wen, rob_commit_br_taken, rob_commit_exp_en}, 0);
        end
        checkOperand("rs1", rs1_Paddr, rs1_rob_ready, rs1_rob_data);
        checkOperand("rs2", rs2_Paddr, rs2_rob_ready, rs2_rob_data);
        if (wb_en && !fl) begin
            foreach (sb[i]) begin
                if (sb[i].tag == wb_tag) begin
                    sb[i].done = 1'b1; sb[i].data = wb_data;
                    sb[i].br = wb_br_taken; sb[i].ex = wb_exp_en;
                end
            end
        end
        if (fl) begin
            sb.delete();
            model_tail = '0;
        end else begin
            if (cm) void'(sb.pop_front());
            if (al) begin
                e.tag = model_tail; e.dst = alloc_dst_addr; e.wen = alloc_dst_wen; e.pc = alloc_pc;
                e.data = '0; e.done = 1'b0; e.br = 1'b0; e.ex = 1'b0;
                sb.push_back(e);
                model_tail = model_tail + 3'd1;
            end
        end
    endtask

    task automatic cycle(input logic a_req, input logic [4:0] a_dst, input logic [31:0] a_pc,
                         input logic w_en, input logic [2:0] w_tag, input logic [31:0] w_data,
                         input logic w_br, input logic w_exp);
        applyStimulus(a_req, a_dst, 1'b1, a_pc, w_en, w_tag, w_data, w_br, w_exp, w_tag, 3'd0);
        modelStep();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_req = 0; alloc_dst_addr = 0; alloc_dst_wen = 0; alloc_pc = 0;
        wb_en = 0; wb_tag = 0; wb_data = 0; wb_br_taken = 0; wb_exp_en = 0;
        rs1_Paddr = 0; rs2_Paddr = 0;
        #1;
        checkOutput("reset_alloc_ready", alloc_ready, 1);
        checkOutput("reset_allocate_en", allocate_en, 0);
        checkOutput("reset_tag", rob_alloc_tag_2rat, 0);
        checkOutput("reset_commit", {commit_en, rob_commit_dst_wen, rob_commit_br_taken,
                                     rob_commit_exp_en, rs1_rob_ready, rs2_rob_ready}, 0);
        checkOutput("reset_commit_pc", rob_commit_pc, 0);
        sb.delete();
        model_tail = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // areq adst apc      wen wtag wdata    e_alloc e_tag e_commit e_pc
        vecs[0]  = '{1, 1, 32'h100, 0, 0, 0,        1, 0, 0, 0};
        vecs[1]  = '{1, 2, 32'h104, 0, 0, 0,        1, 1, 0, 0};
        vecs[2]  = '{1, 3, 32'h108, 0, 0, 0,        1, 2, 0, 0};
        vecs[3]  = '{0, 0, 0,       1, 2, 32'h22,   0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0,       1, 0, 32'h20,   0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0,       0, 0, 0,        0, 0, 1, 32'h100};
        vecs[6]  = '{0, 0, 0,       0, 0, 0,        0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0,       1, 1, 32'h21,   0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0,       0, 0, 0,        0, 0, 1, 32'h104};
        vecs[9]  = '{0, 0, 0,       0, 0, 0,        0, 0, 1, 32'h108};
        vecs[10] = '{0, 0, 0,       0, 0, 0,        0, 0, 0, 0};
        rst_n = 1'b1;
        dut_commits = 0;
        doReset();

        $display("[TB] in-order retire");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].areq, vecs[i].adst, 1'b1, vecs[i].apc, vecs[i].wen,
                          vecs[i].wtag, vecs[i].wdata, 1'b0, 1'b0, vecs[i].wtag, 3'd1);
            checkOutput($sformatf("vec%0d_alloc", i), allocate_en, vecs[i].e_alloc);
            if (vecs[i].e_alloc) checkOutput($sformatf("vec%0d_tag", i), rob_alloc_tag_2rat, vecs[i].e_tag);
            checkOutput($sformatf("vec%0d_commit", i), commit_en, vecs[i].e_commit);
            if (vecs[i].e_commit) checkOutput($sformatf("vec%0d_pc", i), rob_commit_pc, vecs[i].e_pc);
            modelStep();
        end

        $display("[TB] bypass");
        cycle(1, 4, 32'h10c, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 3'd3, 32'hDEAD, 0, 0, 3'd3, 3'd3);
        checkOutput("bypass_ready", rs1_rob_ready, 1);
        checkOutput("bypass_data", rs1_rob_data, 32'hDEAD);
        modelStep();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fill");
        doReset();
        for (int i = 0; i < 8; i++) cycle(1, 5'(i + 8), 32'h400 + 32'(4 * i), 0, 0, 0, 0, 0);
        cycle(1, 5'd20, 32'h4F0, 0, 0, 0, 0, 0);
        checkOutput("full_ready", alloc_ready, 0);
        checkOutput("full_alloc", allocate_en, 0);
        cycle(1, 5'd20, 32'h4F0, 1, 3'd0, 32'h80, 0, 0);
        applyStimulus(1, 5'd20, 1'b1, 32'h4F0, 0, 0, 0, 0, 0, 3'd0, 3'd7);
        checkOutput("full_commit_ready", alloc_ready, 0);
        checkOutput("full_commit_en", commit_en, 1);
        modelStep();
        for (int t = 1; t < 8; t++) cycle(0, 0, 0, 1, 3'(t), 32'h80 + 32'(t), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] branch flush");
        doReset();
        for (int i = 0; i < 4; i++) cycle(1, 5'(i + 1), 32'h200 + 32'(4 * i), 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3'd0, 32'h33, 1, 0);
        applyStimulus(1, 5'd9, 1'b1, 32'h2F0, 1, 3'd1, 32'h44, 0, 0, 3'd1, 3'd2);
        checkOutput("flush_commit", commit_en, 1);
        checkOutput("flush_br", rob_commit_br_taken, 1);
        checkOutput("flush_alloc", allocate_en, 0);
        modelStep();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 3'd2);
        checkOutput("post_flush_tag", rob_alloc_tag_2rat, 0);
        checkOutput("post_flush_commit", commit_en, 0);
        checkOutput("post_flush_ready", rs1_rob_ready, 0);
        modelStep();
        cycle(1, 5'd6, 32'h500, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3'd1, 32'h55, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] exception");
        doReset();
        cycle(1, 5'd5, 32'h300, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3'd0, 32'h55, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0);
        checkOutput("exp_en", rob_commit_exp_en, 1);
        checkOutput("exp_dst_wen", rob_commit_dst_wen, 0);
        checkOutput("exp_dst_addr", rob_commit_dst_addr_2rat, 0);
        modelStep();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] wrap");
        doReset();
        dut_commits = 0;
        for (int i = 0; i < 22; i++) begin
            cycle(i < 20, 5'(i), 32'h1000 + 32'(4 * i), (i >= 1) && (i <= 20), 3'(i - 1),
                  32'hA000 + 32'(i - 1), 0, 0);
        end
        checkOutput("wrap_commits", dut_commits, 20);

        $display("[TB] async reset");
        doReset();
        cycle(1, 5'd1, 32'h600, 0, 0, 0, 0, 0);
        cycle(1, 5'd2, 32'h604, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_tag", rob_alloc_tag_2rat, 0);
        checkOutput("async_ready", alloc_ready, 1);
        checkOutput("async_rs1", rs1_rob_ready, 0);
        doReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
